// File: rtl/ic_hc_pkg.sv
// ic_hc_pkg: definitions shared by the RLE symbol generator, its interface
// and its category encoder.
//   state_t  - generator FSM states
//   ZRL_RUN  - run field carried by a zero-run-length symbol
//   sz_w()   - width of the size (magnitude category) field for a coefficient width
//   comp_w() - width of the component id for a component count
package ic_hc_pkg;

    typedef enum logic [1:0] {
        S_RUN = 2'd0,
        S_ZRL = 2'd1,
        S_SYM = 2'd2
    } state_t;

    localparam logic [3:0] ZRL_RUN = 4'd15;

    // A difference of two COEF_W-bit values needs COEF_W+1 bits, so the
    // category ranges 0..COEF_W+1.
    function automatic int sz_w(input int coef_w);
        return $clog2(coef_w + 2);
    endfunction

    // A single component still needs a one-bit id port.
    function automatic int comp_w(input int num_comp);
        return (num_comp > 1) ? $clog2(num_comp) : 1;
    endfunction

endpackage

// File: rtl/ic_hc_rle_symbol_generator_if.sv
// ic_hc_rle_symbol_generator_if: coefficient input stream, predictor clear
// and symbol output stream of the RLE symbol generator.
//   in_coef/in_comp/in_valid/in_ready - coefficient stream (zigzag order)
//   pred_clear                        - zero all DC predictors
//   out_run/out_size/out_value        - symbol fields
//   out_is_dc/out_zrl/out_eob/out_last- symbol kind flags
//   out_valid/out_ready               - symbol stream handshake
// Modports: master drives coefficients and consumes symbols, slave is the generator.
interface ic_hc_rle_symbol_generator_if #(
    parameter int COEF_W   = 13,
    parameter int NUM_COMP = 3
);
    import ic_hc_pkg::*;

    localparam int SZ_W   = sz_w(COEF_W);
    localparam int COMP_W = comp_w(NUM_COMP);

    logic signed [COEF_W-1:0] in_coef;
    logic [COMP_W-1:0]        in_comp;
    logic                     in_valid;
    logic                     in_ready;
    logic                     pred_clear;

    logic [3:0]               out_run;
    logic [SZ_W-1:0]          out_size;
    logic [COEF_W:0]          out_value;
    logic                     out_is_dc;
    logic                     out_zrl;
    logic                     out_eob;
    logic                     out_last;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output in_coef, in_comp, in_valid, pred_clear, out_ready,
        input  in_ready, out_run, out_size, out_value,
               out_is_dc, out_zrl, out_eob, out_last, out_valid
    );

    modport slave (
        input  in_coef, in_comp, in_valid, pred_clear, out_ready,
        output in_ready, out_run, out_size, out_value,
               out_is_dc, out_zrl, out_eob, out_last, out_valid
    );

endinterface

// File: rtl/ic_hc_category.sv
// ic_hc_category: combinational magnitude-category encoder.
//   x     - signed COEF_W+1-bit value (DC difference or sign-extended AC)
//   size  - number of significant bits of |x|, 0 for x = 0
//   value - x for x >= 0, else (x-1) masked to size bits; upper bits zero
module ic_hc_category
    import ic_hc_pkg::*;
#(
    parameter int COEF_W = 13,
    parameter int SZ_W   = sz_w(COEF_W)
) (
    input  logic signed [COEF_W:0] x,
    output logic [SZ_W-1:0]        size,
    output logic [COEF_W:0]        value
);

    localparam int W = COEF_W + 1;

    logic [W-1:0] mag;
    logic [W-1:0] x_m1;
    logic [W-1:0] mask;

    always_comb begin
        mag  = x[W-1] ? (~x + 1'b1) : x;
        size = '0;
        for (int i = 0; i < W; i++) begin
            if (mag[i]) size = SZ_W'(i + 1);
        end
        for (int i = 0; i < W; i++) begin
            mask[i] = (SZ_W'(i) < size);
        end
        // Negative values use the one's-complement form of |x|.
        x_m1  = x - 1'b1;
        value = x[W-1] ? (x_m1 & mask) : x;
    end

endmodule

// File: rtl/ic_hc_rle_symbol_generator.sv
// ic_hc_rle_symbol_generator: turns a zigzag stream of quantised coefficients
// into run/size/value symbols (DC difference, ZRL, AC, EOB).
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   ifc   - slave side of ic_hc_rle_symbol_generator_if (coefficients in,
//           symbols out, predictor clear)
//
// state | meaning
// S_RUN | accepting coefficients, counting zero runs
// S_ZRL | ZRL symbols pending in the output register, input stalled
// S_SYM | held AC symbol in the output register, input stalled
module ic_hc_rle_symbol_generator
    import ic_hc_pkg::*;
#(
    parameter int COEF_W    = 13,
    parameter int NUM_COMP  = 3,
    parameter int BLOCK_LEN = 64
) (
    input  logic clk,
    input  logic reset,
    ic_hc_rle_symbol_generator_if.slave ifc
);

    localparam int SZ_W   = sz_w(COEF_W);
    localparam int W      = COEF_W + 1;
    localparam int COMP_W = comp_w(NUM_COMP);
    localparam int IDX_W  = $clog2(BLOCK_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_LEN - 1);

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [IDX_W-1:0]         run_q, run_d;
    logic [IDX_W-1:0]         zrl_q, zrl_d;
    logic [3:0]               held_run_q, held_run_d;
    logic [SZ_W-1:0]          held_size_q, held_size_d;
    logic [W-1:0]             held_value_q, held_value_d;
    logic                     held_last_q, held_last_d;
    logic signed [COEF_W-1:0] pred_q [NUM_COMP];
    logic signed [COEF_W-1:0] pred_d [NUM_COMP];

    logic                     out_valid_q;
    logic                     ld;
    logic [3:0]               sym_run;
    logic [SZ_W-1:0]          sym_size;
    logic [W-1:0]             sym_value;
    logic                     sym_dc, sym_zrl, sym_eob, sym_last;

    logic                     out_free, xfer, is_dc, is_last, coef_zero;
    logic [COMP_W-1:0]        comp_sel;
    logic signed [COEF_W-1:0] pred_eff;
    logic signed [W-1:0]      diff, coef_ext, cat_in;
    logic [SZ_W-1:0]          cat_size;
    logic [W-1:0]             cat_value;

    assign out_free     = !out_valid_q || ifc.out_ready;
    assign ifc.in_ready = (state_q == S_RUN) && out_free;
    assign xfer         = ifc.in_valid && ifc.in_ready;
    assign is_dc        = (idx_q == '0);
    assign is_last      = (idx_q == LAST_IDX);
    assign coef_zero    = (ifc.in_coef == '0);

    // Out-of-range component ids fall back to predictor 0; a clear in the
    // same cycle as the DC coefficient makes that DC use a zero predictor.
    assign comp_sel = (int'(ifc.in_comp) < NUM_COMP) ? ifc.in_comp : '0;
    assign pred_eff = ifc.pred_clear ? '0 : pred_q[comp_sel];
    assign diff     = {ifc.in_coef[COEF_W-1], ifc.in_coef} - {pred_eff[COEF_W-1], pred_eff};
    assign coef_ext = {ifc.in_coef[COEF_W-1], ifc.in_coef};
    assign cat_in   = is_dc ? diff : coef_ext;

    ic_hc_category #(
        .COEF_W (COEF_W)
    ) u_category (
        .x     (cat_in),
        .size  (cat_size),
        .value (cat_value)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        run_d        = run_q;
        zrl_d        = zrl_q;
        held_run_d   = held_run_q;
        held_size_d  = held_size_q;
        held_value_d = held_value_q;
        held_last_d  = held_last_q;
        pred_d       = pred_q;
        ld           = 1'b0;
        sym_run      = '0;
        sym_size     = '0;
        sym_value    = '0;
        sym_dc       = 1'b0;
        sym_zrl      = 1'b0;
        sym_eob      = 1'b0;
        sym_last     = 1'b0;

        if (ifc.pred_clear) pred_d = '{default: '0};

        unique case (state_q)
            S_RUN: begin
                if (xfer) begin
                    idx_d = is_last ? '0 : idx_q + 1'b1;
                    run_d = '0;
                    if (is_dc) begin
                        pred_d[comp_sel] = ifc.in_coef;
                        ld        = 1'b1;
                        sym_size  = cat_size;
                        sym_value = cat_value;
                        sym_dc    = 1'b1;
                        sym_last  = is_last;
                    end else if (coef_zero) begin
                        // Trailing zeros collapse into EOB regardless of run length.
                        if (is_last) begin
                            ld       = 1'b1;
                            sym_eob  = 1'b1;
                            sym_last = 1'b1;
                        end else begin
                            run_d = run_q + 1'b1;
                        end
                    end else if (int'(run_q) >= 16) begin
                        // First ZRL goes out now; the rest are counted down in S_ZRL.
                        ld           = 1'b1;
                        sym_run      = ZRL_RUN;
                        sym_zrl      = 1'b1;
                        zrl_d        = (run_q >> 4) - 1'b1;
                        held_run_d   = 4'(run_q);
                        held_size_d  = cat_size;
                        held_value_d = cat_value;
                        held_last_d  = is_last;
                        state_d      = S_ZRL;
                    end else begin
                        ld        = 1'b1;
                        sym_run   = 4'(run_q);
                        sym_size  = cat_size;
                        sym_value = cat_value;
                        sym_last  = is_last;
                    end
                end
            end
            S_ZRL: begin
                if (out_free) begin
                    ld = 1'b1;
                    if (zrl_q != '0) begin
                        sym_run = ZRL_RUN;
                        sym_zrl = 1'b1;
                        zrl_d   = zrl_q - 1'b1;
                    end else begin
                        sym_run   = held_run_q;
                        sym_size  = held_size_q;
                        sym_value = held_value_q;
                        sym_last  = held_last_q;
                        state_d   = S_SYM;
                    end
                end
            end
            S_SYM: begin
                if (out_free) state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_RUN;
            idx_q         <= '0;
            run_q         <= '0;
            zrl_q         <= '0;
            held_run_q    <= '0;
            held_size_q   <= '0;
            held_value_q  <= '0;
            held_last_q   <= 1'b0;
            pred_q        <= '{default: '0};
            out_valid_q   <= 1'b0;
            ifc.out_run   <= '0;
            ifc.out_size  <= '0;
            ifc.out_value <= '0;
            ifc.out_is_dc <= 1'b0;
            ifc.out_zrl   <= 1'b0;
            ifc.out_eob   <= 1'b0;
            ifc.out_last  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            run_q        <= run_d;
            zrl_q        <= zrl_d;
            held_run_q   <= held_run_d;
            held_size_q  <= held_size_d;
            held_value_q <= held_value_d;
            held_last_q  <= held_last_d;
            pred_q       <= pred_d;
            out_valid_q  <= ld || (out_valid_q && !ifc.out_ready);
            if (ld) begin
                ifc.out_run   <= sym_run;
                ifc.out_size  <= sym_size;
                ifc.out_value <= sym_value;
                ifc.out_is_dc <= sym_dc;
                ifc.out_zrl   <= sym_zrl;
                ifc.out_eob   <= sym_eob;
                ifc.out_last  <= sym_last;
            end
        end
    end

    assign ifc.out_valid = out_valid_q;

endmodule
